// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encoding and mode constants for serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : fa_cell
// Description : One-bit combinational full adder.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic s_o,
   output logic co_o
);

   assign s_o  = a_i ^ b_i ^ cin_i;
   assign co_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial two's-complement add/subtract, LSB first, with a
//               start/busy/done handshake and held result outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             mode_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             fa_s, fa_co;

   fa_cell u_fa (
      .a_i   (a_q[0]),
      .b_i   (b_q[0]),
      .cin_i (c_q),
      .s_o   (fa_s),
      .co_o  (fa_co)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = (mode_i == MODE_SUB) ? ~b_i : b_i;
               c_d     = mode_i;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_d             = a_q >> 1;
            b_d             = b_q >> 1;
            res_d           = res_q >> 1;
            res_d[WIDTH-1]  = fa_s;
            c_d             = fa_co;
            cnt_d           = cnt_q + CNT_W'(1);
            // On the last bit, c_q is the carry into the MSB.
            if (cnt_q == LAST_CNT) begin
               sum_d   = res_d;
               cout_d  = fa_co;
               ovf_d   = c_q ^ fa_co;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy_o = (state_q == ST_RUN);
   assign done_o = (state_q == ST_DONE);
   assign sum_o  = sum_q;
   assign cout_o = cout_q;
   assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n = 1'b0, start = 1'b0, mode = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;

   logic         rst1_n = 1'b0, start1 = 1'b0, mode1 = 1'b0;
   logic [0:0]   a1 = '0, b1 = '0;
   logic         busy1, done1, cout1, ovf1;
   logic [0:0]   sum1;

   int n_vec = 0;
   int n_bad = 0;

   serial_adder #(.WIDTH(W)) dut8 (
      .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .a_i(a), .b_i(b),
      .busy_o(busy), .done_o(done), .sum_o(sum), .cout_o(cout), .ovf_o(ovf));

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .start_i(start1), .mode_i(mode1), .a_i(a1), .b_i(b1),
      .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1), .ovf_o(ovf1));

   // Returns {ovf, cout, sum} from plain integer arithmetic on w-bit values.
   function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                          input logic m, input int w);
      longint unsigned md, ux, uy, s;
      longint          sx, sy, r;
      logic            co, ov;
      md = 64'd1 << w;
      ux = 64'(x) & (md - 1);
      uy = 64'(y) & (md - 1);
      sx = (ux >= md / 2) ? longint'(ux) - longint'(md) : longint'(ux);
      sy = (uy >= md / 2) ? longint'(uy) - longint'(md) : longint'(uy);
      if (m) begin
         s  = (ux + md - uy) % md;
         co = (ux >= uy);
         r  = sx - sy;
      end else begin
         s  = (ux + uy) % md;
         co = (ux + uy >= md);
         r  = sx + sy;
      end
      ov = (r < -longint'(md / 2)) || (r >= longint'(md / 2));
      return {ov, co, 32'(s)};
   endfunction

   // Model: cycles remaining in the busy+done window after an accepted start.
   int           m_left = 0;
   logic [W-1:0] m_sum = '0, p_sum = '0;
   logic         m_cout = 0, m_ovf = 0, p_cout = 0, p_ovf = 0;
   logic [33:0]  r8;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
      end else if (m_left == 0) begin
         if (start) begin
            r8 = ref_op(32'(a), 32'(b), mode, W);
            p_sum = r8[W-1:0]; p_cout = r8[32]; p_ovf = r8[33];
            m_left = W + 1;
         end
      end else begin
         if (m_left == 2) begin
            m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
         end
         m_left = m_left - 1;
      end
   end

   int          m1_left = 0;
   logic [0:0]  m1_sum = '0, p1_sum = '0;
   logic        m1_cout = 0, m1_ovf = 0, p1_cout = 0, p1_ovf = 0;
   logic [33:0] r1;

   always @(posedge clk or negedge rst1_n) begin
      if (!rst1_n) begin
         m1_left = 0; m1_sum = '0; m1_cout = 0; m1_ovf = 0;
      end else if (m1_left == 0) begin
         if (start1) begin
            r1 = ref_op(32'(a1), 32'(b1), mode1, 1);
            p1_sum = r1[0]; p1_cout = r1[32]; p1_ovf = r1[33];
            m1_left = 2;
         end
      end else begin
         if (m1_left == 2) begin
            m1_sum = p1_sum; m1_cout = p1_cout; m1_ovf = p1_ovf;
         end
         m1_left = m1_left - 1;
      end
   end

   always @(negedge clk) begin
      n_vec++;
      if ({busy, done, sum, cout, ovf} !== {(m_left >= 2), (m_left == 1), m_sum, m_cout, m_ovf}) begin
         n_bad++;
         $display("FAIL cyc8 t=%0t got busy=%b done=%b sum=%h cout=%b ovf=%b exp busy=%b done=%b sum=%h cout=%b ovf=%b",
                  $time, busy, done, sum, cout, ovf, (m_left >= 2), (m_left == 1), m_sum, m_cout, m_ovf);
      end
      n_vec++;
      if ({busy1, done1, sum1, cout1, ovf1} !== {(m1_left >= 2), (m1_left == 1), m1_sum, m1_cout, m1_ovf}) begin
         n_bad++;
         $display("FAIL cyc1 t=%0t got busy=%b done=%b sum=%h cout=%b ovf=%b exp busy=%b done=%b sum=%h cout=%b ovf=%b",
                  $time, busy1, done1, sum1, cout1, ovf1, (m1_left >= 2), (m1_left == 1), m1_sum, m1_cout, m1_ovf);
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for done on the WIDTH=8 instance, counting busy cycles.
   task automatic wait_done8(input string nm, output int busy_cnt);
      int k = 0;
      busy_cnt = 0;
      while (!done && k < 3 * W) begin
         if (busy) busy_cnt++;
         step();
         k++;
      end
      chk({nm, "_timeout"}, 32'(done), 32'd1);
   endtask

   task automatic run8(input string nm, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic xm, input logic [W-1:0] es, input logic ec, input logic eo);
      int bc;
      a = xa; b = xb; mode = xm; start = 1'b1;
      step();
      start = 1'b0; a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
      wait_done8(nm, bc);
      chk({nm, "_busy_cycles"}, 32'(bc), 32'(W));
      chk({nm, "_sum"}, 32'(sum), 32'(es));
      chk({nm, "_cout"}, 32'(cout), 32'(ec));
      chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
      chk({nm, "_model"}, {m_ovf, m_cout, 22'd0, m_sum}, {eo, ec, 22'd0, es});
      step();
   endtask

   initial begin
      int k;
      int bc;
      repeat (3) step();
      chk("rst_outs", {busy, done, cout, ovf, 20'd0, sum}, 32'd0);
      chk("rst_outs1", {busy1, done1, cout1, ovf1, 27'd0, sum1}, 32'd0);
      rst_n = 1'b1; rst1_n = 1'b1;
      step();

      run8("add_ovf", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
      run8("add_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run8("sub_borrow", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
      run8("sub_ovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

      // Restart request during RUN must be ignored.
      a = 8'h03; b = 8'h04; mode = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      a = 8'hAA; b = 8'h55; start = 1'b1;
      step();
      start = 1'b0;
      wait_done8("restart", bc);
      chk("restart_sum", 32'(sum), 32'h07);
      repeat (W + 3) step();
      chk("restart_hold", 32'(sum), 32'h07);

      // Reset in the middle of an operation.
      a = 8'h5A; b = 8'h3C; mode = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      rst_n = 1'b0;
      step();
      chk("midrst", {busy, done, 22'd0, sum}, 32'd0);
      rst_n = 1'b1;
      step();
      run8("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

      // WIDTH=1: 1+1 -> sum 0, cout 1, ovf 1.
      a1 = 1'b1; b1 = 1'b1; mode1 = 1'b0; start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("w1_busy", 32'(busy1), 32'd1);
      step();
      chk("w1_done", 32'(done1), 32'd1);
      chk("w1_result", {29'd0, ovf1, cout1, sum1}, {29'd0, 1'b1, 1'b1, 1'b0});
      step();

      // Randomized traffic on both instances, including start during RUN/DONE.
      for (int i = 0; i < 1500; i++) begin
         start  = ($urandom_range(0, 3) == 0);
         a      = W'($urandom);
         b      = W'($urandom);
         mode   = 1'($urandom);
         start1 = ($urandom_range(0, 2) == 0);
         a1     = 1'($urandom);
         b1     = 1'($urandom);
         mode1  = 1'($urandom);
         rst_n  = ($urandom_range(0, 199) != 0);
         rst1_n = ($urandom_range(0, 199) != 0);
         step();
      end
      rst_n = 1'b1; rst1_n = 1'b1; start = 1'b0; start1 = 1'b0;
      k = 0;
      repeat (W + 3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, bit-serial two's-complement add/subtract unit. It is the sequential successor of the one-bit combinational adder.
- One full-adder cell plus a carry flip-flop processes WIDTH-bit operands LSB-first, one bit per clock.
- A start/busy/done handshake lets a top-level controller (switch/button front end) launch an operation and read a held result on LEDs or segment displays.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start
- a  input  WIDTH  first operand; captured with start
- b  input  WIDTH  second operand; captured with start
- busy  output  1  high while an operation is in progress (RUN)
- done  output  1  one-cycle pulse, result just became valid
- sum  output  WIDTH  result; held stable between completions
- cout  output  1  final carry out (subtract: 1 = no borrow)
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. busy=0, done=0, sum=0, cout=0, ovf=0. Shift registers, counter and carry FF are all 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on the edge where start=1:
  - Capture a into shift reg A.
  - Capture b into shift reg B; B receives ~b when mode=1.
  - Carry FF = mode, so subtract is a + ~b + 1.
  - cnt = 0.
- RUN, each edge:
  - Full-adder cell computes s = A[0]^B[0]^c and c' = majority(A[0],B[0],c).
  - s shifts into the result register MSB; A and B shift right; carry FF = c'; cnt++.
  - On the edge where cnt==WIDTH-1, the carry into the MSB (the current c) is latched for ovf.
- RUN -> DONE on the edge completing bit WIDTH-1:
  - sum = full result register.
  - cout = c'.
  - ovf = latched carry-in XOR c'.
- DONE: done=1 for exactly one cycle, then unconditionally -> IDLE.
- busy = (state==RUN).
- Latency: start sampled at edge 0 -> done high during the cycle following edge WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start while RUN or DONE is ignored; no queuing. a, b and mode may change freely after the capture edge.
- sum/cout/ovf change only at RUN->DONE or at reset. Intermediate shifting uses a separate register, so outputs never show partial results.
- WIDTH=1: single RUN cycle; ovf = carry-in XOR carry-out of bit 0.
- Reset mid-RUN aborts the operation: outputs return to reset values and no done pulse is produced.
- No arithmetic wrap other than natural modulo 2^WIDTH.

Decomposition:
- Shared package serial_adder_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- One sub-module, fa_cell: combinational full adder, inputs a, b, cin; outputs s, co. Instantiated once. The datapath and FSM live in serial_adder.

Test Plan (WIDTH=8 unless noted):
- Add with signed overflow: a=0x5A, b=0x3C, mode=0, start 1 cycle -> busy high 8 cycles, done pulse once; sum=0x96, cout=0, ovf=1.
- Add with unsigned wrap: a=0xFF, b=0x01, mode=0 -> sum=0x00, cout=1, ovf=0.
- Subtract with borrow: a=0x10, b=0x20, mode=1 -> sum=0xF0, cout=0, ovf=0.
- Subtract with signed overflow: a=0x80, b=0x01, mode=1 -> sum=0x7F, cout=1, ovf=1.
- Ignored restart: a=0x03, b=0x04 add started; during RUN assert start with a=0xAA, b=0x55 -> single done, sum=0x07. Outputs hold 0x07 until the next IDLE start.
- Reset mid-operation: start 0x5A+0x3C, drop rst_n at RUN cycle 4 -> busy=0, sum=0, no done pulse. After release, a new 0x01+0x01 gives sum=0x02. Repeat with WIDTH=1: 1+1 -> sum=0, cout=1, ovf=1.
